// File: rtl/axi_slave_rw_sched_if.sv
// AXI-style request/data/response bundle between a master and the rw scheduler.
// Carries AW/W/B and AR/R handshakes plus the memory-side strobes and status.
// Combinational readies only; no storage in the interface itself.
interface axi_slave_rw_sched_if #(
  parameter int LEN_BITS = 4
);
  logic                awvalid;
  logic [LEN_BITS-1:0] awlen;
  logic                awready;
  logic                wvalid;
  logic                wlast;
  logic                wready;
  logic                bvalid;
  logic                bready;
  logic                arvalid;
  logic [LEN_BITS-1:0] arlen;
  logic                arready;
  logic                rdata_ok;
  logic                rvalid;
  logic                rlast;
  logic                rready;
  logic                mem_wr_en;
  logic                mem_rd_en;
  logic [LEN_BITS-1:0] beat_cnt;
  logic                wr_err;

  modport slave (
    input  awvalid, awlen, wvalid, wlast, bready, arvalid, arlen, rdata_ok, rready,
    output awready, wready, bvalid, arready, rvalid, rlast,
           mem_wr_en, mem_rd_en, beat_cnt, wr_err
  );

  modport master (
    output awvalid, awlen, wvalid, wlast, bready, arvalid, arlen, rdata_ok, rready,
    input  awready, wready, bvalid, arready, rvalid, rlast,
           mem_wr_en, mem_rd_en, beat_cnt, wr_err
  );
endinterface

// File: rtl/axi_slave_rw_sched.sv
// Serialises AW/AR bursts onto a single-ported memory, one burst at a time, round-robin on ties.
// Latency: handshake in cycle N, first data beat eligible in N+1; one beat per cycle max.
// Backpressure: wready high for the whole write burst, rvalid follows rdata_ok, beats wait on rready/bready.
module axi_slave_rw_sched #(
  parameter int LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_slave_rw_sched_if.slave axi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_BITS-1:0] r_len;
  logic [LEN_BITS-1:0] r_cnt;
  logic                r_last_dir;   // 1 = last completed burst was a write
  logic                r_wr_err;

  logic w_at_last;
  logic w_awready;
  logic w_arready;
  logic w_wready;
  logic w_wbeat;
  logic w_bvalid;
  logic w_rvalid;
  logic w_rlast;
  logic w_rbeat;

  // Burst end is decided purely by the beat counter against the latched length.
  assign w_at_last = (r_cnt == r_len);

  // Next-state and handshake decode; everything is forced quiet while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_arready   = 1'b0;
    w_wready    = 1'b0;
    w_wbeat     = 1'b0;
    w_bvalid    = 1'b0;
    w_rvalid    = 1'b0;
    w_rlast     = 1'b0;
    w_rbeat     = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the direction not served last time wins.
        if (axi.awvalid && (!axi.arvalid || !r_last_dir)) begin
          w_awready   = 1'b1;
          w_state_nxt = WR_DATA;
        end else if (axi.arvalid) begin
          w_arready   = 1'b1;
          w_state_nxt = RD_DATA;
        end
      end
      WR_DATA: begin
        w_wready = 1'b1;
        w_wbeat  = axi.wvalid;
        if (w_wbeat && w_at_last) begin
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        w_bvalid = 1'b1;
        if (axi.bready) begin
          w_state_nxt = IDLE;
        end
      end
      RD_DATA: begin
        w_rvalid = axi.rdata_ok;
        w_rlast  = w_rvalid && w_at_last;
        w_rbeat  = w_rvalid && axi.rready;
        if (w_rbeat && w_at_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_state_nxt = IDLE;
      w_awready   = 1'b0;
      w_arready   = 1'b0;
      w_wready    = 1'b0;
      w_wbeat     = 1'b0;
      w_bvalid    = 1'b0;
      w_rvalid    = 1'b0;
      w_rlast     = 1'b0;
      w_rbeat     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst length latch, beat counter, arbitration history and sticky wlast error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_last_dir <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      if (w_awready) begin
        r_len    <= axi.awlen;
        r_cnt    <= '0;
        r_wr_err <= 1'b0;
      end
      if (w_arready) begin
        r_len <= axi.arlen;
        r_cnt <= '0;
      end
      if (w_wbeat) begin
        if (axi.wlast != w_at_last) begin
          r_wr_err <= 1'b1;
        end
        r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
      end
      if (w_bvalid && axi.bready) begin
        r_last_dir <= 1'b1;
      end
      if (w_rbeat) begin
        r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        if (w_at_last) begin
          r_last_dir <= 1'b0;
        end
      end
    end
  end

  assign axi.awready   = w_awready;
  assign axi.arready   = w_arready;
  assign axi.wready    = w_wready;
  assign axi.bvalid    = w_bvalid;
  assign axi.rvalid    = w_rvalid;
  assign axi.rlast     = w_rlast;
  assign axi.mem_wr_en = w_wbeat;
  assign axi.mem_rd_en = w_rbeat;
  assign axi.beat_cnt  = rst ? '0 : r_cnt;
  assign axi.wr_err    = rst ? 1'b0 : r_wr_err;

endmodule

// File: tb/tb_axi_slave_rw_sched.sv
// Random burst traffic against a transaction-level model of the scheduler.
// Latency: checks every cycle between handshake and burst completion.
// Backpressure: randomises wvalid, rdata_ok, rready and bready with bounded stalls.
module tb_axi_slave_rw_sched;

  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_slave_rw_sched_if #(.LEN_BITS(LB)) bus ();

  axi_slave_rw_sched #(.LEN_BITS(LB)) dut (
    .clk (clk),
    .rst (rst),
    .axi (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model state.
  bit m_last_dir = 1'b0;  // direction of last completed burst, 1 = write
  bit m_wr_err   = 1'b0;
  bit pend_w     = 1'b0;
  bit pend_r     = 1'b0;
  int wlen       = 0;
  int rlen       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    bus.awvalid  = 1'b0;
    bus.awlen    = '0;
    bus.wvalid   = 1'b0;
    bus.wlast    = 1'b0;
    bus.bready   = 1'b0;
    bus.arvalid  = 1'b0;
    bus.arlen    = '0;
    bus.rdata_ok = 1'b0;
    bus.rready   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wready"}, 32'(bus.wready), 32'd0);
    check({tag, "_bvalid"}, 32'(bus.bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    check({tag, "_rlast"},  32'(bus.rlast),  32'd0);
    check({tag, "_wr_en"},  32'(bus.mem_wr_en), 32'd0);
    check({tag, "_rd_en"},  32'(bus.mem_rd_en), 32'd0);
    check({tag, "_beat"},   32'(bus.beat_cnt), 32'd0);
  endtask

  task automatic run_write(input int len);
    int k = 0;
    int stall = 0;
    int budget = 0;
    bit err = 1'b0;
    bit wv;
    bit last_ok;
    m_wr_err = 1'b0;
    while (k <= len && budget < 200) begin
      budget++;
      wv = ($urandom_range(0, 9) < 7) || (stall >= 3);
      stall = wv ? 0 : stall + 1;
      last_ok = ($urandom_range(0, 9) != 0);
      bus.wvalid = wv;
      bus.wlast  = wv ? ((k == len) ~^ last_ok) ? 1'b1 : 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("wd_wready",  32'(bus.wready), 32'd1);
      check("wd_wr_en",   32'(bus.mem_wr_en), 32'(wv));
      check("wd_beat",    32'(bus.beat_cnt), 32'(k));
      check("wd_wr_err",  32'(bus.wr_err), 32'(err));
      check("wd_awready", 32'(bus.awready), 32'd0);
      check("wd_arready", 32'(bus.arready), 32'd0);
      check("wd_bvalid",  32'(bus.bvalid), 32'd0);
      check("wd_rvalid",  32'(bus.rvalid), 32'd0);
      step();
      if (wv) begin
        if (bus.wlast != (k == len)) err = 1'b1;
        k++;
      end
    end
    if (k <= len) check("wd_timeout", 32'(k), 32'(len + 1));
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    m_wr_err = err;
    stall = 0;
    budget = 0;
    begin
      bit br;
      do begin
        budget++;
        br = ($urandom_range(0, 2) == 0) || (stall >= 3);
        stall++;
        bus.bready = br;
        @(negedge clk);
        check("wr_bvalid",  32'(bus.bvalid), 32'd1);
        check("wr_wready",  32'(bus.wready), 32'd0);
        check("wr_wr_en",   32'(bus.mem_wr_en), 32'd0);
        check("wr_beat",    32'(bus.beat_cnt), 32'd0);
        check("wr_wr_err",  32'(bus.wr_err), 32'(err));
        check("wr_awready", 32'(bus.awready), 32'd0);
        check("wr_arready", 32'(bus.arready), 32'd0);
        step();
      end while (!br && budget < 20);
    end
    bus.bready = 1'b0;
    m_last_dir = 1'b1;
  endtask

  task automatic run_read(input int len);
    int k = 0;
    int stall = 0;
    int budget = 0;
    bit ok;
    bit rr;
    while (k <= len && budget < 300) begin
      budget++;
      ok = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 7);
      if (stall >= 3) begin
        ok = 1'b1;
        rr = 1'b1;
      end
      stall = (ok && rr) ? 0 : stall + 1;
      bus.rdata_ok = ok;
      bus.rready   = rr;
      @(negedge clk);
      check("rd_rvalid",  32'(bus.rvalid), 32'(ok));
      check("rd_rlast",   32'(bus.rlast), 32'(ok && (k == len)));
      check("rd_rd_en",   32'(bus.mem_rd_en), 32'(ok && rr));
      check("rd_beat",    32'(bus.beat_cnt), 32'(k));
      check("rd_wready",  32'(bus.wready), 32'd0);
      check("rd_bvalid",  32'(bus.bvalid), 32'd0);
      check("rd_awready", 32'(bus.awready), 32'd0);
      check("rd_arready", 32'(bus.arready), 32'd0);
      step();
      if (ok && rr) k++;
    end
    if (k <= len) check("rd_timeout", 32'(k), 32'(len + 1));
    bus.rdata_ok = 1'b0;
    bus.rready   = 1'b0;
    m_last_dir = 1'b0;
  endtask

  initial begin
    bit exp_w;
    bit exp_r;
    int gap;

    // Reset, with a request already present: nothing may be acknowledged.
    drive_quiet();
    rst = 1'b1;
    bus.awvalid = 1'b1;
    step();
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check_quiet("rst");
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    step();
    bus.awvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(bus.awready), 32'd0);
    check_quiet("post_rst");
    step();

    for (int it = 0; it < 40; it++) begin
      gap = (it == 0) ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("gap_awready", 32'(bus.awready), 32'd0);
        check("gap_arready", 32'(bus.arready), 32'd0);
        check("gap_wr_err",  32'(bus.wr_err), 32'(m_wr_err));
        check_quiet("gap");
        step();
      end
      if (it == 0) begin
        pend_w = 1'b1;
        wlen   = 3;
        pend_r = 1'b1;
        rlen   = 15;
      end else begin
        if (!pend_w && $urandom_range(0, 1) == 1) begin
          pend_w = 1'b1;
          wlen   = int'($urandom_range(0, 15));
        end
        if (!pend_r && $urandom_range(0, 1) == 1) begin
          pend_r = 1'b1;
          rlen   = int'($urandom_range(0, 15));
        end
        if (!pend_w && !pend_r) begin
          pend_w = 1'b1;
          wlen   = int'($urandom_range(0, 15));
        end
      end
      bus.awvalid = pend_w;
      bus.awlen   = 4'(wlen);
      bus.arvalid = pend_r;
      bus.arlen   = 4'(rlen);
      exp_w = pend_w && (!pend_r || !m_last_dir);
      exp_r = pend_r && !exp_w;
      @(negedge clk);
      check("arb_awready", 32'(bus.awready), 32'(exp_w));
      check("arb_arready", 32'(bus.arready), 32'(exp_r));
      check("arb_wr_err",  32'(bus.wr_err), 32'(m_wr_err));
      check_quiet("arb");
      step();
      // Scramble the length inputs after the handshake so only the latched value counts.
      if (exp_w) begin
        pend_w = 1'b0;
        bus.awvalid = 1'b0;
        bus.awlen = 4'($urandom_range(0, 15));
        run_write(wlen);
      end else begin
        pend_r = 1'b0;
        bus.arvalid = 1'b0;
        bus.arlen = 4'($urandom_range(0, 15));
        run_read(rlen);
      end
    end

    // Reset in the middle of a write burst abandons it without a response.
    pend_w = 1'b0;
    pend_r = 1'b0;
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b1;
    bus.awlen   = 4'd7;
    @(negedge clk);
    check("mr_awready", 32'(bus.awready), 32'd1);
    step();
    bus.awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.wvalid = 1'b1;
      bus.wlast  = 1'b0;
      if (k == 2) rst = 1'b1;
      @(negedge clk);
      if (k < 2) check("mr_beat", 32'(bus.beat_cnt), 32'(k));
      else       check("mr_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      step();
    end
    rst = 1'b0;
    m_last_dir = 1'b0;
    m_wr_err   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mr_wready", 32'(bus.wready), 32'd0);
      check("mr_bvalid", 32'(bus.bvalid), 32'd0);
      check("mr_beat0",  32'(bus.beat_cnt), 32'd0);
      check("mr_wr_en",  32'(bus.mem_wr_en), 32'd0);
      step();
    end
    bus.wvalid = 1'b0;

    // After reset the write side wins a tie again.
    bus.awvalid = 1'b1;
    bus.awlen   = 4'd0;
    bus.arvalid = 1'b1;
    bus.arlen   = 4'd0;
    @(negedge clk);
    check("post_mr_awready", 32'(bus.awready), 32'd1);
    check("post_mr_arready", 32'(bus.arready), 32'd0);
    step();
    bus.awvalid = 1'b0;
    run_write(0);
    bus.arvalid = 1'b1;
    @(negedge clk);
    check("post_mr_ar_turn", 32'(bus.arready), 32'd1);
    step();
    bus.arvalid = 1'b0;
    run_read(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
